// File: rtl/iccm_boot_loader.sv
// UART-fed boot loader: assembles a framed program image into 32-bit words,
// writes them to the ICCM and holds the core in reset until the checksum verifies.
module iccm_boot_loader #(
    parameter int MaxWords = 1024,
    parameter int AddrW    = 12
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             prog_i,
    input  logic             rx_i,
    input  logic [15:0]      clks_per_bit,
    output logic             we_o,
    output logic [AddrW-1:0] addr_o,
    output logic [31:0]      wdata_o,
    output logic             reset_o,
    output logic             done_o,
    output logic             err_o
);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {IDLE, SYNC, LEN0, LEN1, DATA, CSUM, DONE, ERR} state_t;

    logic        rx_meta;
    logic        rx_sync;
    logic        rx_prev;
    rx_state_t   rx_state;
    logic [15:0] bit_cnt;
    logic [15:0] cpb;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic        byte_valid;
    logic        frame_err;

    state_t      state;
    state_t      next_state;
    logic [7:0]  len_lo;
    logic [15:0] len;
    logic [15:0] len_full;
    logic [15:0] word_cnt;
    logic [1:0]  byte_idx;
    logic [31:0] word_reg;
    logic [31:0] assembled;
    logic [7:0]  xor_acc;
    logic        start_load;
    logic        take_len_lo;
    logic        take_len_hi;
    logic        take_data;
    logic        set_done;
    logic        set_err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Bit timing is latched at the start edge so a mid-byte change only affects the next byte.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_state <= RX_IDLE;
            bit_cnt  <= 16'd0;
            cpb      <= 16'd0;
            bit_idx  <= 3'd0;
            shift    <= 8'd0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        cpb      <= clks_per_bit;
                        bit_cnt  <= (clks_per_bit >> 1) - 16'd1;
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (bit_cnt == 16'd0) begin
                        if (rx_sync) begin
                            rx_state <= RX_IDLE;
                        end else begin
                            bit_cnt  <= cpb - 16'd1;
                            bit_idx  <= 3'd0;
                            rx_state <= RX_DATA;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                RX_DATA: begin
                    if (bit_cnt == 16'd0) begin
                        shift   <= {rx_sync, shift[7:1]};
                        bit_cnt <= cpb - 16'd1;
                        if (bit_idx == 3'd7) begin
                            rx_state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                RX_STOP: begin
                    if (bit_cnt == 16'd0) begin
                        rx_state <= RX_IDLE;
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    assign byte_valid = (rx_state == RX_STOP) && (bit_cnt == 16'd0);
    assign frame_err  = byte_valid && !rx_sync;
    assign len_full   = {shift, len_lo};

    always_comb begin
        assembled = word_reg;
        assembled[{byte_idx, 3'b000} +: 8] = shift;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // An abort on prog_i outranks a framing error, which outranks the byte itself.
    always_comb begin
        next_state  = state;
        start_load  = 1'b0;
        take_len_lo = 1'b0;
        take_len_hi = 1'b0;
        take_data   = 1'b0;
        set_done    = 1'b0;
        set_err     = 1'b0;
        case (state)
            IDLE: begin
                if (prog_i) begin
                    next_state = SYNC;
                    start_load = 1'b1;
                end
            end
            DONE, ERR: begin
                if (!prog_i) begin
                    next_state = IDLE;
                end
            end
            default: begin
                if (!prog_i) begin
                    next_state = IDLE;
                    set_err    = 1'b1;
                end else if (frame_err) begin
                    next_state = ERR;
                    set_err    = 1'b1;
                end else if (byte_valid) begin
                    case (state)
                        SYNC: begin
                            if (shift == 8'hA5) begin
                                next_state = LEN0;
                            end
                        end
                        LEN0: begin
                            take_len_lo = 1'b1;
                            next_state  = LEN1;
                        end
                        LEN1: begin
                            take_len_hi = 1'b1;
                            if (len_full == 16'd0 || len_full > 16'(MaxWords)) begin
                                next_state = ERR;
                                set_err    = 1'b1;
                            end else begin
                                next_state = DATA;
                            end
                        end
                        DATA: begin
                            take_data = 1'b1;
                            if (byte_idx == 2'd3 && word_cnt == len - 16'd1) begin
                                next_state = CSUM;
                            end
                        end
                        CSUM: begin
                            if (shift == xor_acc) begin
                                next_state = DONE;
                                set_done   = 1'b1;
                            end else begin
                                next_state = ERR;
                                set_err    = 1'b1;
                            end
                        end
                        default: next_state = ERR;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            we_o     <= 1'b0;
            addr_o   <= '0;
            wdata_o  <= 32'd0;
            done_o   <= 1'b0;
            err_o    <= 1'b0;
            len_lo   <= 8'd0;
            len      <= 16'd0;
            word_cnt <= 16'd0;
            byte_idx <= 2'd0;
            word_reg <= 32'd0;
            xor_acc  <= 8'd0;
        end else begin
            we_o <= 1'b0;
            if (start_load) begin
                done_o   <= 1'b0;
                err_o    <= 1'b0;
                addr_o   <= '0;
                word_cnt <= 16'd0;
                byte_idx <= 2'd0;
                word_reg <= 32'd0;
                xor_acc  <= 8'd0;
            end
            if (set_done) begin
                done_o <= 1'b1;
            end
            if (set_err) begin
                err_o <= 1'b1;
            end
            if (take_len_lo) begin
                len_lo <= shift;
            end
            if (take_len_hi) begin
                len <= len_full;
            end
            if (take_data) begin
                xor_acc  <= xor_acc ^ shift;
                byte_idx <= byte_idx + 2'd1;
                word_reg <= assembled;
                if (byte_idx == 2'd3) begin
                    we_o     <= 1'b1;
                    addr_o   <= word_cnt[AddrW-1:0];
                    wdata_o  <= assembled;
                    word_cnt <= word_cnt + 16'd1;
                end
            end
        end
    end

    assign reset_o = (state == IDLE) || (state == DONE);

endmodule

// File: doc/iccm_boot_loader.md
# iccm_boot_loader

UART-fed boot loader that sits directly upstream of the instruction-memory controller. It receives a framed program image on the programming UART line, assembles little-endian 32-bit words, and drives the ICCM controller write port (we/addr/wdata). It also holds the core reset low while loading and releases it only after the image checksum verifies.

## Interface
Parameters:
- MaxWords, 1024: ICCM depth in words; upper bound on the frame length field.
- AddrW, 12: width of the word address output.

Ports:
- clk_i  in  1  system clock; the block runs on this single clock.
- rst_i  in  1  reset; synchronous, active-high.
- prog_i  in  1  programming enable, level; high requests a load.
- rx_i  in  1  UART RX line, asynchronous, idles high.
- clks_per_bit  in  16  clock cycles per UART bit; ≥4; sampled at each start bit.
- we_o  out  1  one-cycle write strobe to the ICCM controller.
- addr_o  out  AddrW  word address of the current write.
- wdata_o  out  32  write data.
- reset_o  out  1  active-low core reset hold (connects as prog_rst_ni).
- done_o  out  1  image loaded and checksum verified.
- err_o  out  1  sticky load error; cleared on the next load start.

## Operation
- RX front end:
  - rx_i passes through a 2-flop synchronizer.
  - A falling edge of the synchronized line starts a byte. The block waits floor(clks_per_bit/2) cycles, then re-checks the line.
  - If the line is high at that check, the start is treated as a glitch and dropped, with no error.
  - Otherwise the block samples 8 data bits (LSB first) at clks_per_bit intervals, then the stop bit.
  - Stop bit = 0 is a framing error.
- Frame format:
  - Sync byte 0xA5.
  - LEN_LO, LEN_HI: word count N, 1..MaxWords.
  - N×4 data bytes, little-endian per word.
  - CSUM: XOR of all data bytes.
- FSM states: IDLE, SYNC, LEN0, LEN1, DATA, CSUM, DONE, ERR.
  - IDLE: when prog_i=1, go to SYNC; clear err_o, done_o, byte counter, address and XOR accumulator.
  - SYNC: a byte equal to 0xA5 goes to LEN0. Any other byte is discarded and the FSM stays in SYNC.
  - LEN0/LEN1: latch N. If N==0 or N>MaxWords, go to ERR.
  - DATA: shift each byte into the word register at position byte_idx and XOR it into the accumulator. After the 4th byte, pulse we_o with addr_o = word index and wdata_o = assembled word. After word N-1 is written, go to CSUM.
  - CSUM: byte equals the accumulator → DONE; otherwise → ERR.
  - DONE: done_o=1, reset_o=1. When prog_i=0, go to IDLE; done_o stays 1 until the next load starts.
  - ERR: err_o=1, reset_o=0. When prog_i=0, go to IDLE (reset_o returns to 1 and err_o stays set).
- Framing error in any state from SYNC through CSUM → ERR.
- prog_i=0 in SYNC..CSUM aborts: set err_o and go directly to IDLE.
- reset_o = 0 in SYNC, LEN0, LEN1, DATA, CSUM and ERR; 1 in IDLE and DONE.
- Bytes arriving while in IDLE or DONE are ignored.

## Timing
- Reset values: state=IDLE, we_o=0, addr_o=0, wdata_o=0, reset_o=1, done_o=0, err_o=0, synchronizer flops=1.
- rx_i to internal sampling latency: 2 cycles.
- Byte valid fires on the cycle the stop bit is sampled. Registered FSM action and outputs follow 1 cycle later:
  - we_o high for exactly one cycle.
  - addr_o and wdata_o are valid in that same cycle and held until the next write.
- reset_o falls 1 cycle after prog_i is seen high in IDLE. It rises 1 cycle after the valid CSUM stop-bit sample.
- Writes are spaced at least 10×clks_per_bit cycles apart. No backpressure: the ICCM controller accepts a write every cycle.
- Address wraps never occur: N ≤ MaxWords, and the last address is N-1 (0x3FF at N=1024).
- rst_i wins over every other input:
  - Asserting rst_i mid-frame returns the block to reset values on the next edge.
  - A partially received byte is discarded.
- clks_per_bit is captured at each start-bit detection. A change mid-byte takes effect on the next byte.

## Test plan
- Happy path, clks_per_bit=16: prog_i=1, send A5 02 00 | 13 00 00 00 | 6F 00 00 00 | 7C.
  - Expect we_o pulses (0x000, 0x00000013), then (0x001, 0x0000006F).
  - Expect reset_o low from load start until the cycle after CSUM, then high; done_o=1, err_o=0.
- Bad checksum: same frame with CSUM 0x00.
  - Expect both writes; then ERR with err_o=1, reset_o=0, done_o=0.
  - Drop prog_i → IDLE, reset_o=1, err_o stays 1.
- Length bounds:
  - LEN=0x0000 → ERR with no we_o.
  - LEN=0x0401 → ERR.
  - LEN=0x0400 with 4096 data bytes → last write at addr_o=0x3FF, then DONE.
- Line noise, clks_per_bit=8: a 2-cycle low glitch before the sync byte produces no byte and no error.
  - A garbage byte 0x55 before A5 is discarded and the load completes.
  - A frame with stop bit = 0 in DATA → ERR.
- Abort and reset:
  - prog_i dropped mid-DATA → IDLE, err_o=1, reset_o=1, no further we_o.
  - rst_i pulsed mid-byte → all outputs return to reset values; the next full frame loads correctly.
